// File: rtl/fc_layer_accumulator_if.sv
// Handshake bundle between the activation streamer and the FC output layer.
// The master drives activations, weights and biases; the slave returns results.
interface fc_layer_accumulator_if #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10
);
    logic                             start;
    logic [0:LAYER_SZ-1][SIZE-1:0]    bias;
    logic                             in_valid;
    logic                             in_ready;
    logic [SIZE-1:0]                  in_data;
    logic [0:LAYER_SZ-1][SIZE-1:0]    weights;
    logic [0:LAYER_SZ-1][SIZE-1:0]    values;
    logic                             done;

    modport master (
        output start, bias, in_valid, in_data, weights,
        input  in_ready, values, done
    );

    modport slave (
        input  start, bias, in_valid, in_data, weights,
        output in_ready, values, done
    );
endinterface

// File: rtl/fc_layer_accumulator.sv
// Sequential FC output layer: streams activations, accumulates LAYER_SZ
// dot products plus bias, then rounds and saturates them to Q8.8.
module fc_layer_accumulator #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10,
    parameter int IN_SZ    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fc_layer_accumulator_if.slave bus
);

    localparam int ACC_W = 2*SIZE + $clog2(IN_SZ) + 1;
    localparam int CNT_W = $clog2(IN_SZ + 1);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] SAT_MAX  =
        ACC_W'((1 << (SIZE-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINISH,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic signed [ACC_W-1:0] acc_q [LAYER_SZ];
    logic signed [ACC_W-1:0] acc_d [LAYER_SZ];

    logic [0:LAYER_SZ-1][SIZE-1:0] values_q, values_d;

    logic signed [2*SIZE-1:0] prod    [LAYER_SZ];
    logic signed [ACC_W-1:0]  rnd     [LAYER_SZ];
    logic [0:LAYER_SZ-1][SIZE-1:0] sat_res;

    logic accept;
    logic xfer;
    logic last;
    logic in_ready_o;
    logic done_o;

    assign accept = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE);
    assign xfer   = bus.in_valid && (state_q == S_ACCUM);
    assign last   = xfer && (cnt_q == CNT_W'(IN_SZ - 1));

    // One full-width Q16.16 product per neuron for the current beat.
    always_comb begin
        for (int k = 0; k < LAYER_SZ; k++) begin
            prod[k] = $signed(bus.in_data) * $signed(bus.weights[k]);
        end
    end

    // Round half up to Q8.8, then clamp into the signed SIZE-bit range.
    always_comb begin
        for (int k = 0; k < LAYER_SZ; k++) begin
            rnd[k] = (acc_q[k] + RND_HALF) >>> 8;
            if (rnd[k] > SAT_MAX) begin
                sat_res[k] = SAT_MAX[SIZE-1:0];
            end else if (rnd[k] < SAT_MIN) begin
                sat_res[k] = SAT_MIN[SIZE-1:0];
            end else begin
                sat_res[k] = rnd[k][SIZE-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_ACCUM;
            S_ACCUM:  if (last)      state_d = S_FINISH;
            S_FINISH:                state_d = S_DONE;
            S_DONE:   if (bus.start) state_d = S_ACCUM;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        values_d = values_q;
        for (int k = 0; k < LAYER_SZ; k++) begin
            acc_d[k] = acc_q[k];
        end

        // Bias is Q8.8; shifting by 8 aligns it with the Q16.16 products.
        if (accept) begin
            cnt_d = '0;
            for (int k = 0; k < LAYER_SZ; k++) begin
                acc_d[k] = ACC_W'($signed(bus.bias[k])) <<< 8;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 0; k < LAYER_SZ; k++) begin
                acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
            end
        end

        if (state_q == S_FINISH) begin
            values_d = sat_res;
        end
    end

    always_comb begin
        in_ready_o = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            S_ACCUM: in_ready_o = 1'b1;
            S_DONE:  done_o     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            values_q <= '0;
            for (int k = 0; k < LAYER_SZ; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            values_q <= values_d;
            for (int k = 0; k < LAYER_SZ; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign bus.in_ready = in_ready_o;
    assign bus.done     = done_o;
    assign bus.values   = values_q;

endmodule

// File: tb/tb_fc_layer_accumulator.sv
// Directed bench for fc_layer_accumulator with IN_SZ=4:
// table of inferences plus reset and back-to-back sequences.
module tb_fc_layer_accumulator;

    localparam int SIZE     = 16;
    localparam int LAYER_SZ = 10;
    localparam int IN_SZ    = 4;
    localparam int NVEC     = 6;

    typedef logic [0:LAYER_SZ-1][SIZE-1:0] vec_t;

    typedef struct {
        string                      name;
        vec_t                       bias;
        logic [0:IN_SZ-1][SIZE-1:0] data;
        vec_t                       w;
        int                         gap;
        bit                         mid_start;
        vec_t                       exp;
    } tv_t;

    logic clk;
    logic rst;

    fc_layer_accumulator_if #(
        .SIZE     (SIZE),
        .LAYER_SZ (LAYER_SZ)
    ) bif ();

    fc_layer_accumulator #(
        .SIZE     (SIZE),
        .LAYER_SZ (LAYER_SZ),
        .IN_SZ    (IN_SZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t prev;
    tv_t  tv [NVEC];

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t fill(logic [SIZE-1:0] v);
        vec_t r;
        for (int k = 0; k < LAYER_SZ; k++) r[k] = v;
        return r;
    endfunction

    function automatic int argmax(vec_t v);
        int best = 0;
        for (int k = 1; k < LAYER_SZ; k++) begin
            if ($signed(v[k]) > $signed(v[best])) best = k;
        end
        return best;
    endfunction

    task automatic run_vec(int i);
        string n = tv[i].name;
        // Start edge carries a junk beat that must not be absorbed.
        @(negedge clk);
        bif.start    = 1'b1;
        bif.bias     = tv[i].bias;
        bif.in_valid = 1'b1;
        bif.in_data  = 16'h7F00;
        bif.weights  = fill(16'h7F00);
        @(negedge clk);
        bif.start    = 1'b0;
        bif.in_valid = 1'b0;
        bif.bias     = fill(16'h1234);
        chk({n, ".ready_start"}, bif.in_ready, 1'b1);
        chk({n, ".done_fall"}, bif.done, 1'b0);
        chk({n, ".values_held"}, bif.values, prev);
        for (int b = 0; b < IN_SZ; b++) begin
            bif.in_valid = 1'b1;
            bif.in_data  = tv[i].data[b];
            bif.weights  = tv[i].w;
            if (tv[i].mid_start && b == 1) begin
                bif.start = 1'b1;
                bif.bias  = fill(16'h7FFF);
            end
            chk({n, ".ready_beat"}, bif.in_ready, 1'b1);
            chk({n, ".values_accum"}, bif.values, prev);
            @(negedge clk);
            bif.in_valid = 1'b0;
            bif.start    = 1'b0;
            if (b < IN_SZ - 1) begin
                for (int g = 0; g < tv[i].gap; g++) begin
                    chk({n, ".ready_gap"}, bif.in_ready, 1'b1);
                    @(negedge clk);
                end
            end
        end
        chk({n, ".ready_finish"}, bif.in_ready, 1'b0);
        chk({n, ".done_finish"}, bif.done, 1'b0);
        @(negedge clk);
        chk({n, ".done"}, bif.done, 1'b1);
        chk({n, ".values"}, bif.values, tv[i].exp);
        chk({n, ".ready_done"}, bif.in_ready, 1'b0);
        prev = tv[i].exp;
    endtask

    initial begin
        tv[0].name = "basic";
        tv[0].bias = fill(16'h0000);
        tv[0].data = {IN_SZ{16'h0100}};
        tv[0].w    = fill(16'h0080);
        tv[0].w[0] = 16'h0200;
        tv[0].gap  = 0;
        tv[0].mid_start = 1'b0;
        tv[0].exp    = fill(16'h0200);
        tv[0].exp[0] = 16'h0800;

        tv[1].name = "round_up";
        tv[1].bias = fill(16'h0000);
        tv[1].data = '0;
        tv[1].data[0] = 16'h0001;
        tv[1].w    = fill(16'h0080);
        tv[1].gap  = 0;
        tv[1].mid_start = 1'b0;
        tv[1].exp  = fill(16'h0001);

        tv[2].name = "round_dn";
        tv[2].bias = fill(16'h0000);
        tv[2].data = '0;
        tv[2].data[0] = 16'h0001;
        tv[2].w    = fill(16'h007F);
        tv[2].gap  = 0;
        tv[2].mid_start = 1'b0;
        tv[2].exp  = fill(16'h0000);

        tv[3].name = "bias_gap";
        tv[3].bias = fill(16'h0000);
        tv[3].bias[3] = 16'h0100;
        tv[3].data = {IN_SZ{16'h0100}};
        tv[3].w    = fill(16'h0040);
        tv[3].gap  = 3;
        tv[3].mid_start = 1'b1;
        tv[3].exp    = fill(16'h0100);
        tv[3].exp[3] = 16'h0200;

        tv[4].name = "round_neg";
        tv[4].bias = fill(16'h0000);
        tv[4].data = '0;
        tv[4].data[0] = 16'h0001;
        tv[4].w    = fill(16'hFF80);
        tv[4].w[8] = 16'hFF00;
        tv[4].w[9] = 16'hFF7F;
        tv[4].gap  = 0;
        tv[4].mid_start = 1'b0;
        tv[4].exp    = fill(16'h0000);
        tv[4].exp[8] = 16'hFFFF;
        tv[4].exp[9] = 16'hFFFF;

        tv[5].name = "saturate";
        tv[5].bias = fill(16'h0000);
        tv[5].bias[0] = 16'hFF00;
        tv[5].data = {IN_SZ{16'h7F00}};
        tv[5].w    = fill(16'h0000);
        tv[5].w[1] = 16'h7F00;
        tv[5].w[2] = 16'h8100;
        tv[5].gap  = 0;
        tv[5].mid_start = 1'b0;
        tv[5].exp    = fill(16'h0000);
        tv[5].exp[0] = 16'hFF00;
        tv[5].exp[1] = 16'h7FFF;
        tv[5].exp[2] = 16'h8000;

        rst          = 1'b1;
        bif.start    = 1'b0;
        bif.bias     = '0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        bif.weights  = '0;
        prev         = '0;

        @(negedge clk);
        chk("rst.done", bif.done, 1'b0);
        chk("rst.ready", bif.in_ready, 1'b0);
        chk("rst.values", bif.values, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.ready", bif.in_ready, 1'b0);

        run_vec(0);
        chk("basic.argmax", 160'(argmax(bif.values)), 160'(0));

        // Abort an inference after two beats with an async reset.
        @(negedge clk);
        bif.start = 1'b1;
        bif.bias  = fill(16'h0000);
        @(negedge clk);
        bif.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bif.in_valid = 1'b1;
            bif.in_data  = 16'h0100;
            bif.weights  = fill(16'h0100);
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        chk("mid.ready_pre", bif.in_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid.done", bif.done, 1'b0);
        chk("mid.values", bif.values, '0);
        chk("mid.ready", bif.in_ready, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        prev = '0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Hold in DONE with stray in_valid; result must stay put.
        @(negedge clk);
        bif.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        chk("hold.done", bif.done, 1'b1);
        chk("hold.values", bif.values, prev);

        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
